// File: rtl/data_mem_responder.sv
// Word-organised data memory answering CPU load/store requests over a req/ack
// handshake, with a fixed number of wait states before each access.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_rd_q;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic        addr_bad;
  logic        access;
  logic        mem_we;

  assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we   = access && we_q && !addr_bad;
  assign wr_idx   = addr_q[AW+1:2];
  // In IDLE the read port follows the incoming address so that a zero-wait
  // access still finds its word already registered one edge later.
  assign rd_idx   = (state_q == IDLE) ? addr_i[AW+1:2] : addr_q[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          be_d    = be_i;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = addr_bad;
          if (!addr_bad && !we_q) rdata_d = mem_rd_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // Array has no reset so it maps onto block RAM with byte-write enables.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) mem[wr_idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
    mem_rd_q <= mem[rd_idx];
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus hand sequences for
// input stability, mid-transaction reset and zero-wait back-to-back operation.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        ack_o, err_o, busy_o;
  logic [31:0] rdata_o;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  data_mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .be_i(be0), .ack_o(ack0), .rdata_o(rdata0),
    .err_o(err0), .busy_o(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One request on the WAIT_CYCLES=2 instance. Returns acceptance cycle and
  // latency (edges from acceptance to ack). Optionally scrambles the inputs
  // once the request has been accepted.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic mutate,
                      output int acc, output int lat, output logic err,
                      output logic [31:0] rd);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
    acc = -1; lat = -1; err = 1'bx; rd = 32'hx;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc < 0 && busy_o) begin
        acc = cyc;
        if (mutate) begin
          addr_i = a ^ 32'h4;
          wdata_i = ~wd;
        end
      end
      if (ack_o) begin
        lat = cyc - acc;
        err = err_o;
        rd = rdata_o;
        break;
      end
    end
    if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
    req_i = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, ack_o}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int acc, lat, prev_acc;
    logic err;
    logic [31:0] rd;
    bit ack_seen;
    logic ack_s[16];
    logic busy_s[16];
    int last_ack;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h10,  32'h11223344, 4'b0101, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 1'b0, 32'hDE22BE44};
    vecs[4]  = '{1'b1, 32'h0,   32'h00000000, 4'b1111, 1'b0, 32'hDE22BE44};
    vecs[5]  = '{1'b0, 32'h12,  32'h0,        4'b0000, 1'b1, 32'hDE22BE44};
    vecs[6]  = '{1'b1, 32'h200, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'hDE22BE44};
    vecs[7]  = '{1'b0, 32'h0,   32'h0,        4'b0000, 1'b0, 32'h00000000};
    vecs[8]  = '{1'b1, 32'h1FC, 32'h12345678, 4'b1111, 1'b0, 32'h00000000};
    vecs[9]  = '{1'b0, 32'h1FC, 32'h0,        4'b0000, 1'b0, 32'h12345678};
    vecs[10] = '{1'b1, 32'h1FC, 32'h0,        4'b0000, 1'b0, 32'h12345678};
    vecs[11] = '{1'b0, 32'h1FC, 32'h0,        4'b0000, 1'b0, 32'h12345678};
    vecs[12] = '{1'b1, 32'h20,  32'hA5A5A5A5, 4'b1111, 1'b0, 32'h12345678};
    vecs[13] = '{1'b1, 32'h44,  32'h00000000, 4'b1111, 1'b0, 32'h12345678};
    vecs[14] = '{1'b0, 32'h20,  32'h0,        4'b0000, 1'b0, 32'hA5A5A5A5};
    vecs[15] = '{1'b0, 32'h44,  32'h0,        4'b0000, 1'b0, 32'h00000000};

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", {31'd0, ack_o}, 32'd0);
    chk("reset_err", {31'd0, err_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;

    prev_acc = -1;
    for (int i = 0; i < 16; i++) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, acc, lat, err, rd);
      $display("vec %0d we=%0b addr=%h wdata=%h be=%b -> err=%0b rdata=%h lat=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, err, rd, lat);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      if (prev_acc >= 0) chk($sformatf("vec%0d_period", i), 32'(acc - prev_acc), 32'd5);
      prev_acc = acc;
    end

    // Inputs scrambled after acceptance must not affect the store.
    xact(1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, 1'b1, acc, lat, err, rd);
    $display("stable store addr=00000040 -> err=%0b", err);
    chk("stable_store_err", {31'd0, err}, 32'd0);
    xact(1'b0, 32'h40, 32'h0, 4'b0000, 1'b0, acc, lat, err, rd);
    $display("stable load addr=00000040 -> rdata=%h", rd);
    chk("stable_load_40", rd, 32'hCAFEF00D);
    xact(1'b0, 32'h44, 32'h0, 4'b0000, 1'b0, acc, lat, err, rd);
    $display("stable load addr=00000044 -> rdata=%h", rd);
    chk("stable_load_44", rd, 32'h00000000);

    // Reset during BUSY of a store to 0x20: no ack, outputs cleared, store dropped.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h0; be_i = 4'b1111;
    acc = -1;
    for (int i = 0; i < 10 && acc < 0; i++) begin
      @(posedge clk); #1;
      if (busy_o) acc = cyc;
    end
    if (acc < 0) chk("rst_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    chk("midrst_ack", {31'd0, ack_o}, 32'd0);
    chk("midrst_err", {31'd0, err_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_rdata", rdata_o, 32'd0);
    req_i = 1'b0;
    ack_seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack_o) ack_seen = 1'b1;
    end
    @(negedge clk);
    rst_i = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_o) ack_seen = 1'b1;
    end
    chk("midrst_no_ack", {31'd0, ack_seen}, 32'd0);
    xact(1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, acc, lat, err, rd);
    $display("post-reset load addr=00000020 -> rdata=%h err=%0b", rd, err);
    chk("midrst_store_dropped", rd, 32'hA5A5A5A5);

    // WAIT_CYCLES=0 with req held high: ack every 3 cycles, single busy-low gap.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1; wdata0 = '0; be0 = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      ack_s[i] = ack0;
      busy_s[i] = busy0;
      if (ack0) chk($sformatf("w0_err_%0d", i), {31'd0, err0}, 32'd1);
      $display("w0 cycle %0d ack=%0b busy=%0b err=%0b", i, ack0, busy0, err0);
    end
    req0 = 1'b0;
    last_ack = -1;
    for (int i = 0; i < 16; i++) begin
      if (ack_s[i]) begin
        if (last_ack >= 0) chk($sformatf("w0_period_%0d", i), 32'(i - last_ack), 32'd3);
        last_ack = i;
      end
    end
    chk("w0_first_busy", {31'd0, busy_s[0]}, 32'd1);
    chk("w0_first_ack", {31'd0, ack_s[1]}, 32'd1);
    for (int i = 1; i < 15; i++) begin
      if (!busy_s[i]) begin
        chk($sformatf("w0_busy_gap_%0d", i), {30'd0, busy_s[i-1], busy_s[i+1]}, 32'd3);
      end
    end
    chk("w0_rdata_held", rdata0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
